dfh_chain_walker: RTL and testbench
===================================

Name: dfh_chain_walker

Overview:
- Walks a Device Feature Header (DFH) linked list over a simple CSR read-request/response interface, starting at a programmable BAR offset.
- Records each feature's 12-bit ID and byte address into an internal table of up to MAX_FEATURES entries.
- Generalises fixed per-feature CSR address constants (e.g. a UART DFH at 0x60000) into run-time discovery. Sits between the host-side CSR master and the unit-test/BFM or management logic that needs feature base addresses.

Parameters:
- ADDR_W, 20, CSR byte-address width; all address arithmetic is modulo 2^ADDR_W with overflow detection.
- MAX_FEATURES, 8, table depth; must be ≥1.
- TIMEOUT_CYCLES, 256, maximum cycles to wait for a read response; must be ≥2.
- BAR_ID, 3'h0, constant driven on rd_req_bar.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begin walk (ignored while busy)
- start_addr  in  ADDR_W  first DFH byte address; sampled on accepted start
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse at walk end (success or error)
- err_code  out  2  0=ok, 1=timeout, 2=table overflow, 3=address overflow/misaligned; held until next start
- feat_count  out  $clog2(MAX_FEATURES+1)  valid entries recorded
- rd_req_valid  out  1  read request valid
- rd_req_ready  in  1  read request accepted
- rd_req_addr  out  ADDR_W  8-byte-aligned DFH address
- rd_req_bar  out  3  BAR select (=BAR_ID)
- rd_rsp_valid  in  1  64-bit response valid
- rd_rsp_data  in  64  DFH contents
- tbl_idx  in  $clog2(MAX_FEATURES)  table read index
- tbl_id  out  12  feature ID at tbl_idx, registered
- tbl_addr  out  ADDR_W  DFH address at tbl_idx, registered

Behaviour:
- Reset: busy=0, done=0, err_code=0, feat_count=0, rd_req_valid=0, rd_req_addr=0, tbl_id=0, tbl_addr=0; all table entries cleared to 0.
- DFH fields: ID=[11:0], next offset=[39:16] (24-bit, byte units), EOL=[40].
- FSM states:
  - IDLE: on start → clear feat_count, err_code=0, cur=start_addr. Go to CHECK.
  - CHECK: if cur[2:0]≠0 → ERR(3); else REQ.
  - REQ: rd_req_valid=1, rd_req_addr=cur. Stay until rd_req_ready. Then WAIT, timer=0.
  - WAIT: timer increments each cycle. On rd_rsp_valid → DECODE, capturing data. If timer reaches TIMEOUT_CYCLES-1 with no response → ERR(1).
  - DECODE:
    - If feat_count==MAX_FEATURES → ERR(2).
    - Otherwise write {ID,cur} at entry feat_count and increment feat_count.
    - If EOL=1 or offset==0 → FIN.
    - Else sum=cur+offset at ADDR_W+1 bits. A carry or (offset≥2^ADDR_W) → ERR(3). Otherwise cur=sum, go to CHECK.
  - FIN / ERR(n): set err_code, pulse done=1 for exactly one cycle, return to IDLE.
- busy=1 in every state except IDLE.
- Response or request-ready seen outside REQ/WAIT is ignored.
- A response arriving in the same cycle as the timeout limit wins: it is treated as valid.
- start while busy has no effect.
- Table contents and feat_count persist after done until the next accepted start.
- tbl_id/tbl_addr update one cycle after tbl_idx changes. Index ≥feat_count returns 0.
- Latency per feature without stalls: CHECK→REQ→WAIT→DECODE = 3 cycles + response latency.
- Reset asserted mid-walk: rd_req_valid drops the next cycle, the FSM returns to IDLE, and no done pulse is generated.

Optional Feature:
- Macro: DFH_CHAIN_WALKER_SEARCH_EN.
- Defined: adds ports search_id in 12, search_hit out 1, search_addr out ADDR_W. The result is registered with 1-cycle latency. It reports the lowest-index valid entry matching search_id. With no match: hit=0, addr=0. Both outputs reset to 0.
- Undefined: these ports and the comparison logic are absent.

Test Plan:
- Single DFH at 0x60000, ID 0x024, EOL=1, ready and response immediate → feat_count=1, tbl[0]={0x024,0x60000}, err_code=0, one done pulse.
- Chain 0x00000(ID 0x0FE, next 0x10000) → 0x10000(ID 0x010, next 0x50000) → 0x60000(ID 0x024, EOL=1) → feat_count=3, addresses 0x00000/0x10000/0x60000 in order.
- rd_req_ready held low 10 cycles, then response delayed 20 cycles → no timeout; rd_req_addr stable while valid&!ready.
- No response, TIMEOUT_CYCLES=16 → done 16 cycles after acceptance, err_code=1. Also: a response on exactly the limit cycle → accepted.
- MAX_FEATURES=2 with a 3-entry chain → err_code=2, feat_count=2. Separately: start_addr=0xFFFF8 with next 0x10 → err_code=3; start_addr=0x4 → err_code=3 with no read issued.
- rst_n low during WAIT → outputs at reset values next cycle, no done. With SEARCH_EN: after the chain test, search_id=0x010 → hit=1, addr=0x10000; search_id=0x999 → hit=0.

Source files
------------

// File: rtl/dfh_chain_walker.sv
// Walks a DFH linked list over a CSR read interface and records each feature ID and address.
// Optional ID search port enabled with `define DFH_CHAIN_WALKER_SEARCH_EN.
module dfh_chain_walker #(
  parameter int         ADDR_W         = 20,
  parameter int         MAX_FEATURES   = 8,
  parameter int         TIMEOUT_CYCLES = 256,
  parameter logic [2:0] BAR_ID         = 3'h0,
  localparam int        CNT_W          = $clog2(MAX_FEATURES + 1),
  localparam int        IDX_W          = (MAX_FEATURES > 1) ? $clog2(MAX_FEATURES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  feat_count,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [2:0]        rd_req_bar,
  input  logic              rd_rsp_valid,
  input  logic [63:0]       rd_rsp_data,
  input  logic [IDX_W-1:0]  tbl_idx,
  output logic [11:0]       tbl_id,
  output logic [ADDR_W-1:0] tbl_addr
`ifdef DFH_CHAIN_WALKER_SEARCH_EN
  ,
  input  logic [11:0]       search_id,
  output logic              search_hit,
  output logic [ADDR_W-1:0] search_addr
`endif
);

  localparam int TM_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SUM_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_WAIT, S_DECODE, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [1:0] term_code_d;

  logic [ADDR_W-1:0] cur_q;
  logic [TM_W-1:0]   timer_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        err_q;

  logic [11:0] rsp_id_q;
  logic [23:0] rsp_off_q;
  logic        rsp_eol_q;

  logic [11:0]       id_q   [MAX_FEATURES];
  logic [ADDR_W-1:0] addr_q [MAX_FEATURES];
  logic [11:0]       tbl_id_q;
  logic [ADDR_W-1:0] tbl_addr_q;

  logic             table_full;
  logic             timer_lim;
  logic             off_big;
  logic [SUM_W-1:0] sum;
  logic             unused_rsp;

  assign table_full = (cnt_q == CNT_W'(MAX_FEATURES));
  assign timer_lim  = (timer_q == TM_W'(TIMEOUT_CYCLES - 1));
  // Offsets wider than the address space can never land on a valid DFH.
  assign off_big    = ((rsp_off_q >> ADDR_W) != 24'd0);
  assign sum        = {1'b0, cur_q} + SUM_W'(rsp_off_q);
  assign unused_rsp = ^{rd_rsp_data[63:41], rd_rsp_data[15:12]};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    term_code_d = 2'd0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: begin
        if (cur_q[2:0] != 3'd0) begin
          state_d     = S_DONE;
          term_code_d = 2'd3;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ:   if (rd_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        // A response on the limit cycle still counts as valid.
        if (rd_rsp_valid) begin
          state_d = S_DECODE;
        end else if (timer_lim) begin
          state_d     = S_DONE;
          term_code_d = 2'd1;
        end
      end
      S_DECODE: begin
        if (table_full) begin
          state_d     = S_DONE;
          term_code_d = 2'd2;
        end else if (rsp_eol_q || (rsp_off_q == 24'd0)) begin
          state_d     = S_DONE;
          term_code_d = 2'd0;
        end else if (sum[ADDR_W] || off_big) begin
          state_d     = S_DONE;
          term_code_d = 2'd3;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    rd_req_valid = (state_q == S_REQ);
  end

  assign rd_req_addr = cur_q;
  assign rd_req_bar  = BAR_ID;
  assign err_code    = err_q;
  assign feat_count  = cnt_q;
  assign tbl_id      = tbl_id_q;
  assign tbl_addr    = tbl_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q   <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      err_q   <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_q <= start_addr;
            cnt_q <= '0;
            err_q <= 2'd0;
          end
        end
        S_REQ:  timer_q <= '0;
        S_WAIT: timer_q <= timer_q + 1'b1;
        S_DECODE: begin
          if (!table_full) cnt_q <= cnt_q + 1'b1;
          if (state_d == S_CHECK) cur_q <= sum[ADDR_W-1:0];
        end
        default: ;
      endcase
      if ((state_d == S_DONE) && (state_q != S_DONE)) err_q <= term_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == S_WAIT) && rd_rsp_valid) begin
      rsp_id_q  <= rd_rsp_data[11:0];
      rsp_off_q <= rd_rsp_data[39:16];
      rsp_eol_q <= rd_rsp_data[40];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_FEATURES; i++) begin
        id_q[i]   <= 12'd0;
        addr_q[i] <= '0;
      end
    end else if ((state_q == S_DECODE) && !table_full) begin
      id_q[IDX_W'(cnt_q)]   <= rsp_id_q;
      addr_q[IDX_W'(cnt_q)] <= cur_q;
    end
  end

  // Entries beyond the current count read as zero even if stale data remains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_id_q   <= 12'd0;
      tbl_addr_q <= '0;
    end else if (CNT_W'(tbl_idx) < cnt_q) begin
      tbl_id_q   <= id_q[tbl_idx];
      tbl_addr_q <= addr_q[tbl_idx];
    end else begin
      tbl_id_q   <= 12'd0;
      tbl_addr_q <= '0;
    end
  end

`ifdef DFH_CHAIN_WALKER_SEARCH_EN
  logic              hit_d, hit_q;
  logic [ADDR_W-1:0] saddr_d, saddr_q;

  // Scan downward so the lowest matching index is the one that sticks.
  always_comb begin
    hit_d   = 1'b0;
    saddr_d = '0;
    for (int i = MAX_FEATURES - 1; i >= 0; i--) begin
      if ((i < int'(cnt_q)) && (id_q[i] == search_id)) begin
        hit_d   = 1'b1;
        saddr_d = addr_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q   <= 1'b0;
      saddr_q <= '0;
    end else begin
      hit_q   <= hit_d;
      saddr_q <= saddr_d;
    end
  end

  assign search_hit  = hit_q;
  assign search_addr = saddr_q;
`endif

endmodule

// File: tb/tb_dfh_chain_walker.sv
// Directed bench for dfh_chain_walker: a small CSR memory responder with controllable
// request-ready and response delays, plus table readback checks.
module tb_dfh_chain_walker;

  localparam int ADDR_W = 20;
  localparam int MAXF   = 4;
  localparam int TMO    = 32;
  localparam int CNT_W  = $clog2(MAXF + 1);
  localparam int IDX_W  = $clog2(MAXF);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              busy, done;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  feat_count;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [2:0]        rd_req_bar;
  logic              rd_rsp_valid;
  logic [63:0]       rd_rsp_data;
  logic [IDX_W-1:0]  tbl_idx;
  logic [11:0]       tbl_id;
  logic [ADDR_W-1:0] tbl_addr;
`ifdef DFH_CHAIN_WALKER_SEARCH_EN
  logic [11:0]       search_id;
  logic              search_hit;
  logic [ADDR_W-1:0] search_addr;
`endif

  dfh_chain_walker #(
    .ADDR_W(ADDR_W), .MAX_FEATURES(MAXF), .TIMEOUT_CYCLES(TMO), .BAR_ID(3'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .busy(busy), .done(done), .err_code(err_code), .feat_count(feat_count),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_bar(rd_req_bar),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .tbl_idx(tbl_idx), .tbl_id(tbl_id), .tbl_addr(tbl_addr)
`ifdef DFH_CHAIN_WALKER_SEARCH_EN
    , .search_id(search_id), .search_hit(search_hit), .search_addr(search_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem [logic [ADDR_W-1:0]];

  int done_n, reads, acc_cyc, done_cyc;
  bit stable_ok;
  logic [ADDR_W-1:0] rsp_addr;
  logic [11:0]       rid;
  logic [ADDR_W-1:0] raddr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dfh(input logic [11:0] id, input logic [23:0] off, input bit eol);
    return {23'd0, eol, off, 4'd0, id};
  endfunction

  task automatic walk(input logic [ADDR_W-1:0] sa, input int rdy_dly, input int rsp_dly,
                      input bit respond);
    int wr, wp;
    bit phase, first;
    logic [ADDR_W-1:0] a0;
    done_n = 0; reads = 0; stable_ok = 1; acc_cyc = -1; done_cyc = -1;
    phase = 0; first = 1; wr = 0; wp = 0; a0 = '0;
    @(negedge clk); start = 1'b1; start_addr = sa;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rd_req_ready = 1'b0; rd_rsp_valid = 1'b0;
      if (done) begin
        done_n++; done_cyc = cyc;
        break;
      end
      if (!phase && rd_req_valid) begin
        if (first) begin a0 = rd_req_addr; first = 0; end
        else if (rd_req_addr !== a0) stable_ok = 0;
        if (wr < rdy_dly) wr++;
        else begin
          rd_req_ready = 1'b1; phase = 1; wp = 0; wr = 0; first = 1;
          reads++; acc_cyc = cyc + 1; rsp_addr = rd_req_addr;
        end
      end else if (phase && respond) begin
        if (wp == rsp_dly) begin
          rd_rsp_valid = 1'b1;
          rd_rsp_data  = mem.exists(rsp_addr) ? mem[rsp_addr] : 64'd0;
          phase = 0;
        end else wp++;
      end
      @(negedge clk);
    end
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0;
    if (done_n != 0) begin
      @(negedge clk);
      if (done) done_n++;
    end
  endtask

  task automatic rd_tbl(input int idx);
    @(negedge clk); tbl_idx = idx[IDX_W-1:0];
    @(negedge clk); rid = tbl_id; raddr = tbl_addr;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0;
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0; tbl_idx = '0;
`ifdef DFH_CHAIN_WALKER_SEARCH_EN
    search_id = 12'h0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
    check("rst_count", feat_count, 0);
    check("rst_req_valid", rd_req_valid, 0);
    check("rst_req_addr", rd_req_addr, 0);
    check("rst_tbl_id", tbl_id, 0);
    check("rst_tbl_addr", tbl_addr, 0);
    check("bar", rd_req_bar, 0);
    rst_n = 1'b1;

    // Single feature
    mem[20'h60000] = dfh(12'h024, 24'h0, 1'b1);
    walk(20'h60000, 0, 0, 1);
    check("single_done", done_n, 1);
    check("single_err", err_code, 0);
    check("single_count", feat_count, 1);
    check("single_busy_after", busy, 0);
    rd_tbl(0); check("single_t0_id", rid, 12'h024); check("single_t0_addr", raddr, 20'h60000);
    rd_tbl(1); check("single_t1_id", rid, 0); check("single_t1_addr", raddr, 0);

    // Three-entry chain
    mem[20'h00000] = dfh(12'h0FE, 24'h10000, 1'b0);
    mem[20'h10000] = dfh(12'h010, 24'h50000, 1'b0);
    walk(20'h00000, 0, 0, 1);
    check("chain_done", done_n, 1);
    check("chain_err", err_code, 0);
    check("chain_count", feat_count, 3);
    check("chain_reads", reads, 3);
    rd_tbl(0); check("chain_t0_id", rid, 12'h0FE); check("chain_t0_addr", raddr, 20'h00000);
    rd_tbl(1); check("chain_t1_id", rid, 12'h010); check("chain_t1_addr", raddr, 20'h10000);
    rd_tbl(2); check("chain_t2_id", rid, 12'h024); check("chain_t2_addr", raddr, 20'h60000);
    rd_tbl(3); check("chain_t3_id", rid, 0);
`ifdef DFH_CHAIN_WALKER_SEARCH_EN
    search_id = 12'h010; @(negedge clk);
    check("search_hit", search_hit, 1); check("search_addr", search_addr, 20'h10000);
    search_id = 12'h999; @(negedge clk);
    check("search_miss", search_hit, 0); check("search_miss_addr", search_addr, 0);
`endif

    // Stalled ready and slow response
    walk(20'h60000, 10, 20, 1);
    check("stall_done", done_n, 1);
    check("stall_err", err_code, 0);
    check("stall_count", feat_count, 1);
    check("stall_addr_stable", stable_ok, 1);

    // No response: timeout
    walk(20'h60000, 0, 0, 0);
    check("tmo_done", done_n, 1);
    check("tmo_err", err_code, 1);
    check("tmo_latency", done_cyc - acc_cyc, TMO);
    check("tmo_count", feat_count, 0);
    @(negedge clk); check("tmo_err_held", err_code, 1);

    // Response on the limit cycle wins; one cycle later loses
    walk(20'h60000, 0, TMO - 1, 1);
    check("limit_err", err_code, 0);
    check("limit_count", feat_count, 1);
    walk(20'h60000, 0, TMO, 1);
    check("late_err", err_code, 1);

    // Table overflow: five-entry chain into a four-entry table
    for (int i = 1; i <= 5; i++)
      mem[ADDR_W'(i * 'h100)] = dfh(12'(12'h100 + i), 24'h100, i == 5);
    walk(20'h00100, 0, 0, 1);
    check("ovf_done", done_n, 1);
    check("ovf_err", err_code, 2);
    check("ovf_count", feat_count, 4);
    check("ovf_reads", reads, 5);
    mem[20'h00400] = dfh(12'h104, 24'h100, 1'b1);
    walk(20'h00100, 0, 0, 1);
    check("full_err", err_code, 0);
    check("full_count", feat_count, 4);
    rd_tbl(3); check("full_t3_id", rid, 12'h104); check("full_t3_addr", raddr, 20'h00400);

    // Address overflow, oversize offset, misaligned start
    mem[20'hFFFF8] = dfh(12'h0AA, 24'h10, 1'b0);
    walk(20'hFFFF8, 0, 0, 1);
    check("aovf_err", err_code, 3);
    check("aovf_count", feat_count, 1);
    mem[20'h00700] = dfh(12'h0BB, 24'h100000, 1'b0);
    walk(20'h00700, 0, 0, 1);
    check("bigoff_err", err_code, 3);
    walk(20'h00004, 0, 0, 1);
    check("misal_done", done_n, 1);
    check("misal_err", err_code, 3);
    check("misal_reads", reads, 0);
    check("misal_count", feat_count, 0);

    // Reset while waiting for a response
    @(negedge clk); start = 1'b1; start_addr = 20'h60000;
    @(negedge clk); start = 1'b0;
    @(negedge clk); check("mid_req_valid", rd_req_valid, 1); rd_req_ready = 1'b1;
    @(negedge clk); rd_req_ready = 1'b0; check("mid_busy_wait", busy, 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_valid", rd_req_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", feat_count, 0);
    check("mid_rst_req_addr", rd_req_addr, 0);
    check("mid_rst_tbl_id", tbl_id, 0);
    rst_n = 1'b1;
    done_n = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("mid_rst_no_done", done_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
